sfp_tx_framer: RTL and testbench
================================

SFP_TX_FRAMER -- requirements
Module: sfp_tx_framer

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, clock cycles per Manchester half-bit (legal range 1..255).
REQ-002 SHALL provide port i_clk  input  1  system clock (40 MHz master clock); the block uses only this one clock.
REQ-003 SHALL provide port i_res  input  1  reset, synchronous to i_clk, active-high.
REQ-004 SHALL provide port i_en  input  1  transmit enable, synchronous to i_clk.
REQ-005 SHALL provide port i_data  input  8  5V-TTL channel inputs, asynchronous to i_clk.
REQ-006 SHALL provide port o_ser  output  1  Manchester serial line towards the LVDS driver.
REQ-007 SHALL provide port o_busy  output  1  high while a frame is being transmitted.
REQ-008 SHALL provide port o_frame_start  output  1  one-cycle pulse on the first cycle of each frame.
REQ-009 SHALL provide port o_frame_cnt  output  16  count of frames started.

Function
REQ-010 SHALL pass each i_data bit through a 2-flip-flop synchronizer; the snapshot source is the synchronizer output, 2 cycles behind i_data.
REQ-011 SHALL implement states IDLE, SYNC, DATA, PARITY.
REQ-012 SHALL hold a half-bit counter at 0 in IDLE; in other states count 0..CLK_DIV-1 and assert an internal tick when the counter equals CLK_DIV-1.
REQ-013 IDLE -> SYNC on the first cycle i_en is sampled high; on that transition latch the synchronized data into an 8-bit snapshot and compute parity = XOR of the snapshot bits (even parity).
REQ-014 SYNC SHALL last 6 half-bits: o_ser high for half-bits 0-2, low for half-bits 3-5 (deliberate Manchester violation for receiver alignment).
REQ-015 DATA SHALL send snapshot bits MSB first, 2 half-bits per bit; bit 1 = high then low, bit 0 = low then high.
REQ-016 PARITY SHALL send the parity bit as one Manchester bit using the same encoding.
REQ-017 A frame SHALL be exactly 24 half-bits = 24*CLK_DIV cycles.
REQ-018 At the last tick of PARITY: if i_en is high, go directly to SYNC with a new snapshot (zero-gap back-to-back frames); otherwise go to IDLE.
REQ-019 i_en deasserting mid-frame SHALL NOT abort the frame; the current frame completes and the block then goes to IDLE.
REQ-020 Changes to i_data mid-frame SHALL NOT affect the frame in flight; only the snapshot is transmitted.
REQ-021 o_ser SHALL be registered and low in IDLE; its first high cycle coincides with o_frame_start.
REQ-022 o_frame_start SHALL be registered and pulse high for exactly one cycle, on the first cycle of SYNC.
REQ-023 o_busy SHALL be high in SYNC, DATA and PARITY, low in IDLE, and stay continuously high across back-to-back frames.
REQ-024 o_frame_cnt SHALL increment by 1 in the cycle o_frame_start is high and wrap from 0xFFFF to 0x0000.

Reset
REQ-025 While i_res is high at a clock edge: state = IDLE, o_ser = 0, o_busy = 0, o_frame_start = 0, o_frame_cnt = 0x0000, half-bit counter = 0, snapshot = 0x00, synchronizer flops = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after the edge, o_ser is 0, and no partial frame resumes after reset is released.
REQ-027 After reset is released with i_en high, the first frame SHALL start on the first edge i_res is sampled low.

Verification
REQ-028 CLK_DIV=2, i_data=0xA5 held, single i_en pulse -> o_ser half-bits H H H L L L | HL LH HL LH LH HL LH HL | LH (parity 0), each half-bit 2 cycles; o_busy high 48 cycles; o_frame_cnt=1.
REQ-029 CLK_DIV=2, i_data=0x01, i_en held high 3 frames -> three contiguous 48-cycle frames, no gap; parity bit HL (1); o_busy never drops; o_frame_start pulses 48 cycles apart; o_frame_cnt=3.
REQ-030 i_data changes 0x00->0xFF in the middle of the DATA state -> current frame carries 0x00 with parity 0; next frame carries 0xFF with parity 0.
REQ-031 i_res asserted at half-bit 10 of a frame -> o_ser=0, o_busy=0, o_frame_cnt=0 after the edge; after release with i_en high, a full fresh frame starts.
REQ-032 Force o_frame_cnt to 0xFFFF, then start one frame -> count reads 0x0000.
REQ-033 CLK_DIV=1, i_data=0x80 -> frame 24 cycles long; data half-bits HL then LH x7; parity HL.

Source files
------------

// File: rtl/sfp_tx_framer.sv
// rtl/sfp_tx_framer.sv - Manchester framer: sync violation, 8 data bits MSB first, even parity
module sfp_tx_framer #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic        o_ser,
    output logic        o_busy,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t        state_q, state_d;
    logic [7:0]    sync1_q, sync1_d;
    logic [7:0]    sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    hb_q, hb_d;
    logic [7:0]    snap_q, snap_d;
    logic          par_q, par_d;
    logic          ser_q, ser_d;
    logic          busy_q, busy_d;
    logic          fs_q, fs_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          tick;
    logic          start;
    logic [2:0]    bit_idx;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state_q     <= IDLE;
            sync1_q     <= 8'h00;
            sync2_q     <= 8'h00;
            cnt_q       <= '0;
            hb_q        <= 5'd0;
            snap_q      <= 8'h00;
            par_q       <= 1'b0;
            ser_q       <= 1'b0;
            busy_q      <= 1'b0;
            fs_q        <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            hb_q        <= hb_d;
            snap_q      <= snap_d;
            par_q       <= par_d;
            ser_q       <= ser_d;
            busy_q      <= busy_d;
            fs_q        <= fs_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // hb_q is the half-bit index within the frame (0..23); state tracks which field it is in
    always_comb begin
        sync1_d     = i_data;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        hb_d        = hb_q;
        snap_d      = snap_q;
        par_d       = par_q;
        fs_d        = 1'b0;
        frame_cnt_d = frame_cnt_q;
        start       = 1'b0;
        tick        = (state_q != IDLE) && (cnt_q == CNT_MAX);

        if (state_q == IDLE) begin
            cnt_d = '0;
            hb_d  = 5'd0;
            start = i_en;
        end else if (!tick) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            hb_d  = hb_q + 5'd1;
            case (state_q)
                SYNC:    if (hb_q == 5'd5)  state_d = DATA;
                DATA:    if (hb_q == 5'd21) state_d = PARITY;
                PARITY:  if (hb_q == 5'd23) begin
                             if (i_en) begin
                                 start = 1'b1;
                             end else begin
                                 state_d = IDLE;
                                 hb_d    = 5'd0;
                             end
                         end
                default: state_d = IDLE;
            endcase
        end

        if (start) begin
            state_d     = SYNC;
            hb_d        = 5'd0;
            cnt_d       = '0;
            snap_d      = sync2_q;
            par_d       = ^sync2_q;
            fs_d        = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Serial output is computed from the next half-bit so the registered line lines up with state
    always_comb begin
        bit_idx = 3'd7 - 3'((hb_d - 5'd6) >> 1);
        ser_d   = 1'b0;
        case (state_d)
            SYNC:    ser_d = (hb_d < 5'd3);
            DATA:    ser_d = snap_d[bit_idx] ^ hb_d[0];
            PARITY:  ser_d = par_d ^ hb_d[0];
            default: ser_d = 1'b0;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign o_ser         = ser_q;
    assign o_busy        = busy_q;
    assign o_frame_start = fs_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sfp_tx_framer.sv
// tb/tb_sfp_tx_framer.sv - scoreboard bench for sfp_tx_framer at CLK_DIV 2 and 1
module tb_sfp_tx_framer;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        en0 = 1'b0, en1 = 1'b0;
    logic [7:0]  data0 = 8'h00, data1 = 8'h00;
    logic        ser0, busy0, fs0, ser1, busy1, fs1;
    logic [15:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic        mon_active[2];
    int          mon_pos[2];
    logic [47:0] mon_got[2];
    logic [47:0] mon_exp[2];
    logic        mon_busybad[2];
    logic [7:0]  mon_d[2];
    logic [15:0] exp_cnt[2];

    sfp_tx_framer #(.CLK_DIV(2)) dut0 (
        .i_clk(clk), .i_res(res), .i_en(en0), .i_data(data0),
        .o_ser(ser0), .o_busy(busy0), .o_frame_start(fs0), .o_frame_cnt(cnt0)
    );

    sfp_tx_framer #(.CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_res(res), .i_en(en1), .i_data(data1),
        .o_ser(ser1), .o_busy(busy1), .o_frame_start(fs1), .o_frame_cnt(cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Reference frame: list of 24 half-bit levels, each stretched to div cycles
    function automatic logic [47:0] frame_bits(input logic [7:0] d, input int div);
        logic [23:0] h;
        logic [47:0] o;
        h = '0;
        o = '0;
        for (int j = 0; j < 3; j++) h[j] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            h[6 + 2*i] = d[7 - i];
            h[7 + 2*i] = ~d[7 - i];
        end
        h[22] = ^d;
        h[23] = ~(^d);
        for (int k = 0; k < 24 * div; k++) o[k] = h[k / div];
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic s, b, f;
            logic [15:0] c;
            int len;
            logic have;
            s   = (k == 0) ? ser0 : ser1;
            b   = (k == 0) ? busy0 : busy1;
            f   = (k == 0) ? fs0 : fs1;
            c   = (k == 0) ? cnt0 : cnt1;
            len = (k == 0) ? 48 : 24;
            if (res) begin
                mon_active[k] = 1'b0;
                exp_cnt[k]    = 16'h0000;
            end else begin
                if (f) begin
                    checks++;
                    if (mon_active[k]) begin
                        errors++;
                        $display("FAIL frame_start_early inst%0d got_pos=%0d required_pos=%0d", k, mon_pos[k], len);
                    end
                    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    checks++;
                    if (!have) begin
                        errors++;
                        $display("FAIL unexpected_frame inst%0d got=start required=none", k);
                        mon_active[k] = 1'b0;
                    end else begin
                        if (k == 0) mon_d[k] = q0.pop_front();
                        else        mon_d[k] = q1.pop_front();
                        mon_exp[k]     = frame_bits(mon_d[k], (k == 0) ? 2 : 1);
                        mon_got[k]     = '0;
                        mon_pos[k]     = 0;
                        mon_busybad[k] = 1'b0;
                        mon_active[k]  = 1'b1;
                        exp_cnt[k]     = exp_cnt[k] + 16'd1;
                        checks++;
                        if (c !== exp_cnt[k]) begin
                            errors++;
                            $display("FAIL frame_cnt inst%0d got=%0h required=%0h", k, c, exp_cnt[k]);
                        end
                    end
                end
                if (mon_active[k]) begin
                    mon_got[k][mon_pos[k]] = s;
                    if (b !== 1'b1) mon_busybad[k] = 1'b1;
                    mon_pos[k]++;
                    if (mon_pos[k] == len) begin
                        checks++;
                        if (mon_got[k] !== mon_exp[k]) begin
                            errors++;
                            $display("FAIL frame_ser inst%0d data=%02h got=%012h required=%012h",
                                     k, mon_d[k], mon_got[k], mon_exp[k]);
                        end
                        checks++;
                        if (mon_busybad[k]) begin
                            errors++;
                            $display("FAIL frame_busy inst%0d got=low required=high", k);
                        end
                        mon_active[k] = 1'b0;
                    end
                end else if (!f) begin
                    checks++;
                    if (s !== 1'b0 || b !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_lines inst%0d got ser=%b busy=%b required ser=0 busy=0", k, s, b);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input int k, input int bound, output int at);
        logic seen;
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if ((k == 0) ? fs0 : fs1) begin
                seen = 1'b1;
                at   = cyc_n;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_frame_start inst%0d got=timeout required=pulse", k);
        end
    endtask

    task automatic wait_idle(input int k, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (k == 0) seen = !busy0 && !fs0;
            else        seen = !busy1 && !fs1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_idle inst%0d got=busy required=idle", k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3;
        logic [7:0] d1, d2;
        cyc(3);
        chk("reset_ser", {31'd0, ser0}, 32'd0);
        chk("reset_busy", {31'd0, busy0}, 32'd0);
        chk("reset_fs", {31'd0, fs0}, 32'd0);
        chk("reset_cnt", {16'd0, cnt0}, 32'd0);
        chk("reset_busy1", {31'd0, busy1}, 32'd0);
        res = 1'b0;
        cyc(2);

        // single frame, 0xA5
        data0 = 8'hA5;
        cyc(3);
        q0.push_back(8'hA5);
        en0 = 1'b1;
        wait_fs(0, 4, t1);
        en0 = 1'b0;
        wait_idle(0, 100);
        chk("single_cnt", {16'd0, cnt0}, 32'd1);

        // three back-to-back frames, 0x01
        data0 = 8'h01;
        cyc(3);
        repeat (3) q0.push_back(8'h01);
        en0 = 1'b1;
        wait_fs(0, 4, t1);
        wait_fs(0, 60, t2);
        wait_fs(0, 60, t3);
        cyc(5);
        en0 = 1'b0;
        chk("b2b_gap1", t2 - t1, 32'd48);
        chk("b2b_gap2", t3 - t2, 32'd48);
        wait_idle(0, 100);
        chk("b2b_cnt", {16'd0, cnt0}, 32'd4);

        // data change mid-frame only reaches the next frame
        data0 = 8'h00;
        cyc(3);
        q0.push_back(8'h00);
        q0.push_back(8'hFF);
        en0 = 1'b1;
        wait_fs(0, 4, t1);
        cyc(20);
        data0 = 8'hFF;
        wait_fs(0, 60, t2);
        en0 = 1'b0;
        wait_idle(0, 100);

        // random single and paired frames
        for (int r = 0; r < 6; r++) begin
            d1 = 8'($urandom);
            data0 = d1;
            cyc(3);
            q0.push_back(d1);
            en0 = 1'b1;
            wait_fs(0, 4, t1);
            if ($urandom_range(0, 1) == 1) begin
                d2 = 8'($urandom);
                cyc($urandom_range(1, 40));
                data0 = d2;
                q0.push_back(d2);
                wait_fs(0, 60, t2);
            end
            en0 = 1'b0;
            wait_idle(0, 100);
        end

        // reset mid-frame, then restart with enable held (synchronizer cleared -> 0x00)
        data0 = 8'h3C;
        cyc(3);
        q0.push_back(8'h3C);
        en0 = 1'b1;
        wait_fs(0, 4, t1);
        cyc(20);
        res = 1'b1;
        @(negedge clk);
        chk("abort_ser", {31'd0, ser0}, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_cnt", {16'd0, cnt0}, 32'd0);
        @(negedge clk);
        q0.push_back(8'h00);
        res = 1'b0;
        @(negedge clk);
        chk("restart_fs", {31'd0, fs0}, 32'd1);
        en0 = 1'b0;
        wait_idle(0, 100);
        chk("restart_cnt", {16'd0, cnt0}, 32'd1);

        // CLK_DIV=1 instance
        data1 = 8'h80;
        cyc(3);
        q1.push_back(8'h80);
        en1 = 1'b1;
        wait_fs(1, 4, t1);
        en1 = 1'b0;
        wait_idle(1, 50);
        for (int r = 0; r < 4; r++) begin
            d1 = 8'($urandom);
            data1 = d1;
            cyc(3);
            q1.push_back(d1);
            en1 = 1'b1;
            wait_fs(1, 4, t1);
            en1 = 1'b0;
            wait_idle(1, 50);
        end

        // counter wrap
        force dut0.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut0.frame_cnt_q;
        exp_cnt[0] = 16'hFFFF;
        data0 = 8'h5A;
        cyc(3);
        q0.push_back(8'h5A);
        en0 = 1'b1;
        wait_fs(0, 4, t1);
        en0 = 1'b0;
        wait_idle(0, 100);
        chk("wrap_cnt", {16'd0, cnt0}, 32'd0);

        cyc(4);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
